// File: rtl/pipe_pkg.sv
// Shared types and constants for the IF/ID pipeline stage: skid-buffer state
// encoding, default payload widths and the bubble instruction.
package pipe_pkg;

  localparam int DEF_PC_W    = 32;
  localparam int DEF_INSTR_W = 32;
  localparam int DEF_CNT_W   = 16;

  // An all-zero word is what decode treats as a bubble after a zeroing flush.
  localparam logic [DEF_INSTR_W-1:0] NOP = '0;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HALF  = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_t;

  function automatic logic holds_entry(input skid_state_t s);
    return s != ST_EMPTY;
  endfunction

endpackage

// File: rtl/if2id_skid_reg_if.sv
// Fetch-to-decode channel of the IF/ID stage: upstream handshake, downstream
// handshake, branch flush and the stall counter readout.
interface if2id_skid_reg_if #(
  parameter int PC_W    = 32,
  parameter int INSTR_W = 32,
  parameter int CNT_W   = 16
);

  // valid/ready: a transfer happens on a rising edge where valid & ready are
  // both 1; valid never waits on ready, and ready here is a function of
  // registered state only, so no combinational path runs from out_ready to in_ready.
  logic               in_valid;
  logic               in_ready;
  logic [PC_W-1:0]    in_pc_plus4;
  logic [INSTR_W-1:0] in_instr;
  logic               flush;
  logic               out_valid;
  logic               out_ready;
  logic [PC_W-1:0]    out_pc_plus4;
  logic [INSTR_W-1:0] out_instr;
  logic [CNT_W-1:0]   stall_cnt;

  modport master (
    output in_valid, in_pc_plus4, in_instr, flush, out_ready,
    input  in_ready, out_valid, out_pc_plus4, out_instr, stall_cnt
  );

  modport slave (
    input  in_valid, in_pc_plus4, in_instr, flush, out_ready,
    output in_ready, out_valid, out_pc_plus4, out_instr, stall_cnt
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter for per-stage performance events; sticks at all-ones
// and clears only on reset.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/if2id_skid_reg.sv
// IF/ID pipeline register with a 2-entry skid buffer: main entry drives decode,
// skid entry absorbs one extra fetch so back-pressure never reaches the PC combinationally.
module if2id_skid_reg
  import pipe_pkg::*;
#(
  parameter int PC_W       = DEF_PC_W,
  parameter int INSTR_W    = DEF_INSTR_W,
  parameter bit FLUSH_ZERO = 1'b1,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  if2id_skid_reg_if.slave      bus,
  output skid_state_t          state_dbg
);

  skid_state_t        state_q;
  logic               out_valid_q;
  logic [PC_W-1:0]    main_pc_q;
  logic [INSTR_W-1:0] main_instr_q;
  logic [PC_W-1:0]    skid_pc_q;
  logic [INSTR_W-1:0] skid_instr_q;
  logic [CNT_W-1:0]   stall_cnt;
  logic               in_fire;
  logic               out_fire;
  logic               stall_inc;

  assign bus.in_ready = (state_q != ST_FULL) & rst;
  assign in_fire      = bus.in_valid & bus.in_ready;
  assign out_fire     = out_valid_q & bus.out_ready;
  assign stall_inc    = out_valid_q & ~bus.out_ready;

  assign bus.out_valid    = out_valid_q;
  assign bus.out_pc_plus4 = main_pc_q;
  assign bus.out_instr    = main_instr_q;
  assign bus.stall_cnt    = stall_cnt;
  assign state_dbg        = state_q;

  // out_valid is registered next to the state so it is a clean flop output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_EMPTY;
      out_valid_q  <= 1'b0;
      main_pc_q    <= '0;
      main_instr_q <= '0;
      skid_pc_q    <= '0;
      skid_instr_q <= '0;
    end else if (bus.flush) begin
      state_q     <= ST_EMPTY;
      out_valid_q <= 1'b0;
      if (FLUSH_ZERO) begin
        main_pc_q    <= '0;
        main_instr_q <= INSTR_W'(NOP);
        skid_pc_q    <= '0;
        skid_instr_q <= INSTR_W'(NOP);
      end
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            main_pc_q    <= bus.in_pc_plus4;
            main_instr_q <= bus.in_instr;
            state_q      <= ST_HALF;
            out_valid_q  <= 1'b1;
          end
        end
        ST_HALF: begin
          if (in_fire && out_fire) begin
            main_pc_q    <= bus.in_pc_plus4;
            main_instr_q <= bus.in_instr;
          end else if (in_fire) begin
            // Decode is stalled: park the newer entry behind the held one.
            skid_pc_q    <= bus.in_pc_plus4;
            skid_instr_q <= bus.in_instr;
            state_q      <= ST_FULL;
          end else if (out_fire) begin
            state_q     <= ST_EMPTY;
            out_valid_q <= 1'b0;
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            main_pc_q    <= skid_pc_q;
            main_instr_q <= skid_instr_q;
            state_q      <= ST_HALF;
          end
        end
        default: begin
          state_q     <= ST_EMPTY;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

endmodule

// File: tb/tb_if2id_skid_reg.sv
// Directed and randomised checks of the IF/ID skid register; three instances
// (zeroing flush, keeping flush, 3-bit stall counter) share one stimulus.
module tb_if2id_skid_reg;
  import pipe_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_pc_plus4 = '0;
  logic [31:0] in_instr = '0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;

  skid_state_t state_a, state_n, state_c;

  int errors = 0;
  int checks = 0;
  logic [63:0] exp_q[$];

  if2id_skid_reg_if #(.PC_W(32), .INSTR_W(32), .CNT_W(16)) bus_a ();
  if2id_skid_reg_if #(.PC_W(32), .INSTR_W(32), .CNT_W(16)) bus_n ();
  if2id_skid_reg_if #(.PC_W(32), .INSTR_W(32), .CNT_W(3))  bus_c ();

  assign bus_a.in_valid = in_valid;    assign bus_n.in_valid = in_valid;    assign bus_c.in_valid = in_valid;
  assign bus_a.in_pc_plus4 = in_pc_plus4; assign bus_n.in_pc_plus4 = in_pc_plus4; assign bus_c.in_pc_plus4 = in_pc_plus4;
  assign bus_a.in_instr = in_instr;    assign bus_n.in_instr = in_instr;    assign bus_c.in_instr = in_instr;
  assign bus_a.flush = flush;          assign bus_n.flush = flush;          assign bus_c.flush = flush;
  assign bus_a.out_ready = out_ready;  assign bus_n.out_ready = out_ready;  assign bus_c.out_ready = out_ready;

  if2id_skid_reg #(.PC_W(32), .INSTR_W(32), .FLUSH_ZERO(1'b1), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .bus(bus_a.slave), .state_dbg(state_a));
  if2id_skid_reg #(.PC_W(32), .INSTR_W(32), .FLUSH_ZERO(1'b0), .CNT_W(16)) dut_keep (
    .clk(clk), .rst(rst), .bus(bus_n.slave), .state_dbg(state_n));
  if2id_skid_reg #(.PC_W(32), .INSTR_W(32), .FLUSH_ZERO(1'b1), .CNT_W(3)) dut_c3 (
    .clk(clk), .rst(rst), .bus(bus_c.slave), .state_dbg(state_c));

  // clock / reset block
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins, input logic rdy);
    in_valid    = v;
    in_pc_plus4 = pc;
    in_instr    = ins;
    out_ready   = rdy;
  endtask

  initial begin
    #2;
    check("rst_out_valid", 64'(bus_a.out_valid), 64'd0);
    check("rst_out_pc", 64'(bus_a.out_pc_plus4), 64'd0);
    check("rst_out_instr", 64'(bus_a.out_instr), 64'd0);
    check("rst_in_ready", 64'(bus_a.in_ready), 64'd0);
    check("rst_stall", 64'(bus_a.stall_cnt), 64'd0);
    check("rst_state", 64'(state_a), 64'(ST_EMPTY));
    #5 rst = 1'b1;
    #1 check("rel_in_ready", 64'(bus_a.in_ready), 64'd1);

    // back-to-back streaming
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'(4 * (i + 1)), 32'hA000_0000 + 32'(i), 1'b1);
      tick();
      check("b2b_valid", 64'(bus_a.out_valid), 64'd1);
      check("b2b_pc", 64'(bus_a.out_pc_plus4), 64'(4 * (i + 1)));
      check("b2b_instr", 64'(bus_a.out_instr), 64'(32'hA000_0000 + 32'(i)));
      check("b2b_in_ready", 64'(bus_a.in_ready), 64'd1);
    end
    drive(1'b0, '0, '0, 1'b1);
    tick();
    check("b2b_drained", 64'(bus_a.out_valid), 64'd0);
    check("b2b_stall", 64'(bus_a.stall_cnt), 64'd0);

    // back-pressure fills the skid entry
    drive(1'b1, 32'h10, 32'h1111_AAAA, 1'b0);
    tick();
    drive(1'b1, 32'h14, 32'h2222_BBBB, 1'b0);
    tick();
    check("bp_state_full", 64'(state_a), 64'(ST_FULL));
    check("bp_in_ready", 64'(bus_a.in_ready), 64'd0);
    check("bp_pc_a", 64'(bus_a.out_pc_plus4), 64'h10);
    check("bp_stall1", 64'(bus_a.stall_cnt), 64'd1);
    drive(1'b0, '0, '0, 1'b0);
    tick();
    tick();
    check("bp_hold_pc", 64'(bus_a.out_pc_plus4), 64'h10);
    check("bp_hold_instr", 64'(bus_a.out_instr), 64'h1111_AAAA);
    check("bp_stall3", 64'(bus_a.stall_cnt), 64'd3);
    out_ready = 1'b1;
    tick();
    check("bp_drain_b", 64'(bus_a.out_pc_plus4), 64'h14);
    check("bp_drain_b_instr", 64'(bus_a.out_instr), 64'h2222_BBBB);
    check("bp_in_ready_back", 64'(bus_a.in_ready), 64'd1);
    check("bp_stall_hold", 64'(bus_a.stall_cnt), 64'd3);
    tick();
    check("bp_empty", 64'(bus_a.out_valid), 64'd0);

    // flush from FULL with an incoming entry
    drive(1'b1, 32'h20, 32'h3333_CCCC, 1'b0);
    tick();
    drive(1'b1, 32'h24, 32'h4444_DDDD, 1'b0);
    tick();
    drive(1'b1, 32'h28, 32'h5555_EEEE, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl_valid", 64'(bus_a.out_valid), 64'd0);
    check("fl_zero_pc", 64'(bus_a.out_pc_plus4), 64'd0);
    check("fl_zero_instr", 64'(bus_a.out_instr), 64'd0);
    check("fl_keep_valid", 64'(bus_n.out_valid), 64'd0);
    check("fl_keep_pc", 64'(bus_n.out_pc_plus4), 64'h20);
    check("fl_keep_instr", 64'(bus_n.out_instr), 64'h3333_CCCC);
    check("fl_stall", 64'(bus_a.stall_cnt), 64'd5);
    drive(1'b0, '0, '0, 1'b1);
    tick();
    check("fl_c_dropped", 64'(bus_a.out_valid), 64'd0);

    // flush from HALF with in_fire and out_fire in the same cycle
    drive(1'b1, 32'h2C, 32'h6666_0000, 1'b1);
    tick();
    drive(1'b1, 32'h30, 32'h7777_0000, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, '0, '0, 1'b1);
    check("fl2_valid", 64'(bus_a.out_valid), 64'd0);
    tick();
    check("fl2_dropped", 64'(bus_a.out_valid), 64'd0);
    check("fl2_stall", 64'(bus_a.stall_cnt), 64'd5);

    // asynchronous reset while FULL
    drive(1'b1, 32'h34, 32'h8888_0000, 1'b0);
    tick();
    drive(1'b1, 32'h38, 32'h9999_0000, 1'b0);
    tick();
    check("ar_full", 64'(state_a), 64'(ST_FULL));
    #2 rst = 1'b0;
    #1;
    check("ar_valid", 64'(bus_a.out_valid), 64'd0);
    check("ar_pc", 64'(bus_a.out_pc_plus4), 64'd0);
    check("ar_instr", 64'(bus_a.out_instr), 64'd0);
    check("ar_in_ready", 64'(bus_a.in_ready), 64'd0);
    check("ar_stall", 64'(bus_a.stall_cnt), 64'd0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check("ar_rel_in_ready", 64'(bus_a.in_ready), 64'd1);
    drive(1'b1, 32'h40, 32'hCAFE_0040, 1'b1);
    tick();
    check("ar_new_valid", 64'(bus_a.out_valid), 64'd1);
    check("ar_new_pc", 64'(bus_a.out_pc_plus4), 64'h40);
    drive(1'b0, '0, '0, 1'b1);
    tick();

    // stall counter saturation on the 3-bit instance
    drive(1'b1, 32'h50, 32'hBEEF_0050, 1'b0);
    tick();
    drive(1'b0, '0, '0, 1'b0);
    for (int i = 0; i < 7; i++) tick();
    check("sat_c3_7", 64'(bus_c.stall_cnt), 64'd7);
    check("sat_a_7", 64'(bus_a.stall_cnt), 64'd7);
    for (int i = 0; i < 3; i++) tick();
    check("sat_c3_hold", 64'(bus_c.stall_cnt), 64'd7);
    check("sat_a_10", 64'(bus_a.stall_cnt), 64'd10);
    out_ready = 1'b1;
    tick();
    check("sat_drained", 64'(bus_a.out_valid), 64'd0);

    // randomised traffic against the scoreboard
    for (int cyc = 0; cyc < 1000; cyc++) begin
      logic        exp_rdy;
      logic        v;
      logic [31:0] pc;
      logic [31:0] ins;
      exp_rdy = (exp_q.size() < 2);
      v   = 1'($urandom_range(0, 1));
      pc  = 32'h1000 + 32'(4 * cyc);
      ins = $urandom;
      drive(v, pc, ins, 1'b0);
      #1 check("rnd_in_ready_r0", 64'(bus_a.in_ready), 64'(exp_rdy));
      out_ready = 1'b1;
      #1 check("rnd_in_ready_r1", 64'(bus_a.in_ready), 64'(exp_rdy));
      out_ready = 1'($urandom_range(0, 1));
      #1 check("rnd_out_valid", 64'(bus_a.out_valid), 64'(exp_q.size() > 0));
      if (out_ready && exp_q.size() > 0) begin
        check("rnd_payload", {bus_a.out_pc_plus4, bus_a.out_instr}, exp_q[0]);
        void'(exp_q.pop_front());
      end
      if (v && exp_rdy) exp_q.push_back({pc, ins});
      tick();
    end
    drive(1'b0, '0, '0, 1'b1);
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) begin
      #1 check("end_payload", {bus_a.out_pc_plus4, bus_a.out_instr}, exp_q[0]);
      void'(exp_q.pop_front());
      tick();
    end
    check("end_queue_empty", 64'(exp_q.size()), 64'd0);
    check("end_out_valid", 64'(bus_a.out_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if2id_skid_reg.md
Name: if2id_skid_reg

Overview:
- Parametrised successor to the fixed IF/ID pipeline latch.
- Carries PC+4 and the instruction word from fetch to decode using a valid/ready handshake.
- A 2-entry skid buffer breaks the combinational ready path, so decode back-pressure never has to reach the PC in the same cycle.
- Supports branch flush with selectable zeroing of the payload, plus a saturating stall-cycle counter for performance analysis.

Parameters:
- PC_W, 32, width of the PC+4 payload field
- INSTR_W, 32, width of the instruction payload field
- FLUSH_ZERO, 1, 1: flush clears the payload registers to 0 (NOP); 0: flush clears only the valid bits
- CNT_W, 16, width of the stall-cycle counter

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  reset; asynchronous, active-low (0 = reset)
- in_valid  in  1  fetch presents a valid entry
- in_ready  out  1  stage can accept an entry this cycle
- in_pc_plus4  in  PC_W  PC+4 from fetch
- in_instr  in  INSTR_W  instruction from fetch
- flush  in  1  kill all held entries (taken branch or jump)
- out_valid  out  1  entry available to decode
- out_ready  in  1  decode accepts the entry (the replacement for the old Write enable)
- out_pc_plus4  out  PC_W  held PC+4
- out_instr  out  INSTR_W  held instruction
- stall_cnt  out  CNT_W  count of cycles with out_valid=1 and out_ready=0

Behaviour:
- Handshake definitions
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - in_ready = (state != FULL) & rst. It is combinational from the registered state only and never depends on out_ready.
- Storage
  - Main register: drives the out_* ports.
  - Skid register: internal only.
- States
  - EMPTY: no entry held.
  - HALF: main register valid.
  - FULL: main and skid registers valid.
  - out_valid = (state != EMPTY), registered.
- Transitions when flush=0
  - EMPTY: in_fire → HALF, main <= in. Otherwise stay in EMPTY.
  - HALF, in_fire & out_fire: stay in HALF, main <= in.
  - HALF, in_fire & !out_ready: → FULL, skid <= in, main unchanged.
  - HALF, !in_fire & out_fire: → EMPTY.
  - HALF, otherwise: hold.
  - FULL: in_ready=0. out_fire → HALF, main <= skid. Otherwise hold.
- Latency and throughput
  - 1 cycle from in_fire to out_valid when the stage is EMPTY or the main entry drains in the same cycle.
  - Sustained throughput of 1 entry per cycle.
  - Order is preserved: the skid entry is always older than any new entry.
- Flush
  - flush has highest priority.
  - Next state is EMPTY, so out_valid=0 on the next cycle.
  - Any in_fire in the flush cycle is discarded.
  - An out_fire in the flush cycle still counts as consumed by decode, because the payload was visible.
  - FLUSH_ZERO=1: main and skid payloads are set to 0.
  - FLUSH_ZERO=0: payloads keep their values.
- Hold
  - When state is unchanged and there is no fire, payload registers keep their values.
  - The outputs are stable while out_valid=1 & out_ready=0.
- stall_cnt
  - Increments on each cycle with out_valid & !out_ready, including flush cycles.
  - Saturates at 2^CNT_W − 1.
  - Cleared only by reset.
- Reset (rst=0, asynchronous)
  - state=EMPTY, out_valid=0, out_pc_plus4=0, out_instr=0, skid payload=0, stall_cnt=0, in_ready=0.
  - Reset asserted mid-transfer drops all held entries immediately, without waiting for a clock edge.
  - After reset is released, in_ready=1 in the same cycle.
- Widths: payload fields are passed through bit-exact, with no extension or truncation.

Decomposition:
- Shared package (pipe_pkg):
  - State encoding: EMPTY=2'd0, HALF=2'd1, FULL=2'd2.
  - Default widths: PC_W=32, INSTR_W=32.
  - NOP constant.
- One natural sub-module: sat_counter (parameter W; ports clk, rst, inc, count). It is reused for other per-stage performance counters.

Test Plan:
- Reset, then 8 back-to-back entries with pc_plus4 = 4, 8, …, 32 and out_ready=1 → each entry appears on the cycle after it was sent, in order; in_ready stays 1; stall_cnt=0.
- Enqueue A (pc 0x10), then hold out_ready=0 while sending B (pc 0x14) → state FULL and in_ready=0. Out shows A for 3 cycles and stall_cnt=3. Raise out_ready → A then B drain on consecutive cycles, and in_ready returns to 1.
- FULL state with flush=1 and in_valid=1 carrying C → next cycle out_valid=0 and C never appears. With FLUSH_ZERO=1, out_instr=0 and out_pc_plus4=0; with FLUSH_ZERO=0, both retain A's values.
- rst=0 asserted between clock edges while FULL → outputs go to 0 and out_valid=0 immediately. After release, a new entry appears with 1-cycle latency.
- CNT_W=3, out_valid held with out_ready=0 for 10 cycles → stall_cnt reaches 7 and holds at 7.
- Randomised in_valid/out_ready at 50% each over 1000 cycles, compared against a FIFO scoreboard → no entry lost, duplicated or reordered, and in_ready never depends combinationally on out_ready.
